// File: rtl/sram_photo_writer.sv
// Streams RGB pixels into one photo slot of the shared SRAM, packing each pixel
// as {R,G} then {B,Y} so the color-transform engine can read it back directly.
module sram_photo_writer #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int N_SLOTS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [1:0]        i_slot,
  input  logic [9:0]        iCol_Max,
  input  logic [9:0]        iRow_Max,
  input  logic              i_abort,
  input  logic              i_pix_valid,
  input  logic [23:0]       i_pix_rgb,
  output logic              o_pix_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] oSRAM_ADDR,
  inout  wire  [DATA_W-1:0] ioSRAM_DQ,
  output logic              oSRAM_WE_N,
  output logic              oSRAM_OE_N,
  output logic              oSRAM_CE_N,
  output logic              oSRAM_LB_N,
  output logic              oSRAM_UB_N
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WR_HI, S_WR_LO} state_t;

  localparam logic [22:0] ADDR_SPAN = 23'd1 << ADDR_W;

  state_t              r_state;
  logic [19:0]         r_size;
  logic [19:0]         r_count;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_pix_b;
  logic [7:0]          r_pix_y;
  logic                r_we_n;
  logic [ADDR_W-1:0]   r_sram_addr;
  logic [DATA_W-1:0]   r_dq;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic [19:0]         w_size;
  logic [21:0]         w_end;
  logic [ADDR_W-1:0]   w_base;
  logic                w_reject;
  logic [15:0]         w_y_sum;
  logic [7:0]          w_y;
  logic                w_last;
  logic                w_accept;

  assign w_size   = {10'd0, iCol_Max} * {10'd0, iRow_Max};
  assign w_end    = ({20'd0, i_slot} + 22'd1) * {1'b0, w_size, 1'b0};
  assign w_base   = ADDR_W'({20'd0, i_slot} * {1'b0, w_size, 1'b0});
  assign w_reject = (iCol_Max == 10'd0) || (iRow_Max == 10'd0) ||
                    ({30'd0, i_slot} >= N_SLOTS) || ({1'b0, w_end} > ADDR_SPAN);

  // Weights sum to 256, so the shifted result always fits in a byte.
  assign w_y_sum = 16'd77  * {8'd0, i_pix_rgb[23:16]} +
                   16'd150 * {8'd0, i_pix_rgb[15:8]} +
                   16'd29  * {8'd0, i_pix_rgb[7:0]};
  assign w_y     = 8'(w_y_sum >> 8);

  assign w_last      = (r_count == r_size - 20'd1);
  assign o_pix_ready = (r_state == S_WAIT) || ((r_state == S_WR_LO) && !w_last);
  assign w_accept    = i_pix_valid && o_pix_ready;

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign oSRAM_ADDR = r_sram_addr;
  assign oSRAM_WE_N = r_we_n;
  assign oSRAM_OE_N = 1'b1;
  assign oSRAM_CE_N = 1'b0;
  assign oSRAM_LB_N = 1'b0;
  assign oSRAM_UB_N = 1'b0;
  assign ioSRAM_DQ  = r_we_n ? {DATA_W{1'bz}} : r_dq;

  // Bus outputs are loaded one state ahead, so each word's ADDR/DQ/WE_N are
  // held from a register for the full cycle of its write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_size      <= '0;
      r_count     <= '0;
      r_addr      <= '0;
      r_pix_b     <= '0;
      r_pix_y     <= '0;
      r_we_n      <= 1'b1;
      r_sram_addr <= '0;
      r_dq        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (i_abort) begin
        r_state <= S_IDLE;
        r_we_n  <= 1'b1;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              if (w_reject) begin
                r_err <= 1'b1;
              end else begin
                r_size  <= w_size;
                r_addr  <= w_base;
                r_count <= '0;
                r_busy  <= 1'b1;
                r_state <= S_WAIT;
              end
            end
          end
          S_WR_HI: begin
            r_we_n      <= 1'b0;
            r_sram_addr <= r_addr;
            r_dq        <= {r_pix_b, r_pix_y};
            r_addr      <= r_addr + 1'b1;
            r_state     <= S_WR_LO;
          end
          S_WR_LO: begin
            r_count <= r_count + 20'd1;
            if (w_last) begin
              r_state <= S_IDLE;
              r_we_n  <= 1'b1;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else if (!w_accept) begin
              r_state <= S_WAIT;
              r_we_n  <= 1'b1;
            end
          end
          default: ;
        endcase

        // Only reachable from S_WAIT or a non-final S_WR_LO, since ready gates it.
        if (w_accept) begin
          r_pix_b     <= i_pix_rgb[7:0];
          r_pix_y     <= w_y;
          r_we_n      <= 1'b0;
          r_sram_addr <= r_addr;
          r_dq        <= i_pix_rgb[23:8];
          r_addr      <= r_addr + 1'b1;
          r_state     <= S_WR_HI;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_photo_writer.sv
// Bench for sram_photo_writer: start-decision table, directed corner sequences and
// random pixel streams compared against a word-list model of the slot layout.
`timescale 1ns/1ps
module tb_sram_photo_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iStart = 1'b0;
  logic [1:0]  iSlot = '0;
  logic [9:0]  iCols = '0;
  logic [9:0]  iRows = '0;
  logic        iAbort = 1'b0;
  logic        pixValid = 1'b0;
  logic [23:0] pixRgb = '0;
  logic        oPixReady, oBusy, oDone, oErr;
  logic [19:0] sramAddr;
  wire  [15:0] sramDq;
  logic        weN, oeN, ceN, lbN, ubN;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] slot;
    logic [9:0] cols;
    logic [9:0] rows;
    bit         expErr;
  } startVec_t;

  typedef struct {
    logic [19:0] addr;
    logic [15:0] data;
  } wordVec_t;

  startVec_t   startTab[11];
  wordVec_t    t1Tab[8];
  logic [23:0] pixList[64];

  logic [19:0] wrAddrQ[$];
  logic [15:0] wrDataQ[$];
  logic [23:0] accQ[$];
  int          protoErr, doneCnt, errCnt;
  int          cyc = 0;
  int          firstWrCyc, lastWrCyc, doneCyc;
  logic        clearReq = 1'b0;

  sram_photo_writer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (iStart),
    .i_slot      (iSlot),
    .iCol_Max    (iCols),
    .iRow_Max    (iRows),
    .i_abort     (iAbort),
    .i_pix_valid (pixValid),
    .i_pix_rgb   (pixRgb),
    .o_pix_ready (oPixReady),
    .o_busy      (oBusy),
    .o_done      (oDone),
    .o_err       (oErr),
    .oSRAM_ADDR  (sramAddr),
    .ioSRAM_DQ   (sramDq),
    .oSRAM_WE_N  (weN),
    .oSRAM_OE_N  (oeN),
    .oSRAM_CE_N  (ceN),
    .oSRAM_LB_N  (lbN),
    .oSRAM_UB_N  (ubN)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: records every written word and accepted pixel, and counts
  // protocol violations (ready during a high-word write, write without accept,
  // OE_N asserted, DQ driven while WE_N is high).
  always @(negedge clk) begin
    if (clearReq) begin
      wrAddrQ.delete();
      wrDataQ.delete();
      accQ.delete();
      protoErr = 0;
      doneCnt = 0;
      errCnt = 0;
      firstWrCyc = -1;
      lastWrCyc = -1;
      doneCyc = -1;
    end else if (rst_n) begin
      if (pixValid && oPixReady) accQ.push_back(pixRgb);
      if (!weN) begin
        if ((wrAddrQ.size() % 2 == 0) && oPixReady) protoErr++;
        wrAddrQ.push_back(sramAddr);
        wrDataQ.push_back(sramDq);
        if (wrAddrQ.size() > 2 * accQ.size()) protoErr++;
        if (firstWrCyc < 0) firstWrCyc = cyc;
        lastWrCyc = cyc;
      end else if (sramDq !== 16'hzzzz) begin
        protoErr++;
      end
      if (oeN !== 1'b1) protoErr++;
      if (oDone) begin
        doneCnt++;
        doneCyc = cyc;
      end
      if (oErr) errCnt++;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic pulseClear();
    clearReq = 1'b1;
    @(negedge clk);
    #1 clearReq = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] slot, input logic [9:0] cols, input logic [9:0] rows);
    @(posedge clk);
    #1;
    iStart = 1'b1;
    iSlot = slot;
    iCols = cols;
    iRows = rows;
    @(posedge clk);
    #1 iStart = 1'b0;
  endtask

  // Offers pixList[0..n-1] in order; when abortAt >= 0, aborts during the
  // high-word write of that pixel and returns just after the abort edge.
  task automatic streamPixels(input string name, input int n, input bit randomValid, input int abortAt);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 1000) begin
      pixRgb = pixList[sent];
      pixValid = randomValid ? ($urandom_range(0, 1) == 1) : 1'b1;
      @(negedge clk);
      if (pixValid && oPixReady) sent++;
      @(posedge clk);
      #1 guard++;
      if (abortAt >= 0 && sent == abortAt + 1) begin
        pixValid = 1'b0;
        iAbort = 1'b1;
        @(posedge clk);
        #1 iAbort = 1'b0;
        break;
      end
    end
    pixValid = 1'b0;
    if (abortAt < 0) checkOutput({name, " pixels sent"}, sent, n);
  endtask

  task automatic waitDone(input string name, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      seen = oDone;
    end
    checkOutput({name, " done seen"}, seen, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Reference layout: pixel k lands at base+2k as {R,G} and base+2k+1 as {B,luma}.
  task automatic compareWrites(input string name, input int base, input int n);
    int r, g, b, y;
    checkOutput({name, " accepted"}, accQ.size(), n);
    checkOutput({name, " words"}, wrAddrQ.size(), 2 * n);
    for (int k = 0; k < accQ.size() && 2 * k + 1 < wrAddrQ.size(); k++) begin
      r = int'(accQ[k][23:16]);
      g = int'(accQ[k][15:8]);
      b = int'(accQ[k][7:0]);
      y = (77 * r + 150 * g + 29 * b) / 256;
      checkOutput($sformatf("%s hi%0d", name, k), {wrAddrQ[2*k], wrDataQ[2*k]},
                  {20'(base + 2 * k), 16'(r * 256 + g)});
      checkOutput($sformatf("%s lo%0d", name, k), {wrAddrQ[2*k+1], wrDataQ[2*k+1]},
                  {20'(base + 2 * k + 1), 16'(b * 256 + y)});
    end
  endtask

  task automatic runJob(input string name, input logic [1:0] slot, input logic [9:0] cols,
                        input logic [9:0] rows, input bit randomValid, input bit useList);
    int n = int'(cols) * int'(rows);
    if (!useList) for (int i = 0; i < n; i++) pixList[i] = 24'($urandom);
    pulseClear();
    applyStimulus(slot, cols, rows);
    streamPixels(name, n, randomValid, -1);
    waitDone(name, 40);
    compareWrites(name, int'(slot) * 2 * n, n);
    checkOutput({name, " protocol"}, protoErr, 0);
    checkOutput({name, " done count"}, doneCnt, 1);
    checkOutput({name, " done latency"}, doneCyc - lastWrCyc, 1);
    checkOutput({name, " busy after"}, oBusy, 0);
  endtask

  initial begin
    startTab[0]  = '{2'd0, 10'd0,    10'd5,   1'b1};
    startTab[1]  = '{2'd1, 10'd3,    10'd0,   1'b1};
    startTab[2]  = '{2'd3, 10'd2,    10'd2,   1'b1};
    startTab[3]  = '{2'd2, 10'd640,  10'd480, 1'b1};
    startTab[4]  = '{2'd1, 10'd512,  10'd512, 1'b0};
    startTab[5]  = '{2'd1, 10'd512,  10'd513, 1'b1};
    startTab[6]  = '{2'd0, 10'd1023, 10'd512, 1'b0};
    startTab[7]  = '{2'd2, 10'd1,    10'd1,   1'b0};
    startTab[8]  = '{2'd0, 10'd1023, 10'd1023, 1'b1};
    startTab[9]  = '{2'd2, 10'd341,  10'd512, 1'b0};
    startTab[10] = '{2'd2, 10'd342,  10'd512, 1'b1};

    t1Tab[0] = '{20'd8,  16'h0A14};
    t1Tab[1] = '{20'd9,  16'h1E12};
    t1Tab[2] = '{20'd10, 16'hFFFF};
    t1Tab[3] = '{20'd11, 16'hFFFF};
    t1Tab[4] = '{20'd12, 16'h0000};
    t1Tab[5] = '{20'd13, 16'h0000};
    t1Tab[6] = '{20'd14, 16'h0102};
    t1Tab[7] = '{20'd15, 16'h0301};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset ctrl", {weN, oeN, ceN, lbN, ubN, oPixReady, oBusy, oDone, oErr}, 9'b110000000);
    checkOutput("reset addr", sramAddr, 0);
    checkOutput("reset dq z", sramDq === 16'hzzzz, 1);
    rst_n = 1'b1;

    $display("[TB] start decision table");
    for (int i = 0; i < 11; i++) begin
      pulseClear();
      applyStimulus(startTab[i].slot, startTab[i].cols, startTab[i].rows);
      @(negedge clk);
      checkOutput($sformatf("start%0d err", i), oErr, startTab[i].expErr);
      checkOutput($sformatf("start%0d busy", i), oBusy, !startTab[i].expErr);
      @(posedge clk);
      #1;
      if (!startTab[i].expErr) begin
        iAbort = 1'b1;
        @(posedge clk);
        #1 iAbort = 1'b0;
      end
      checkOutput($sformatf("start%0d err pulses", i), errCnt, startTab[i].expErr);
      checkOutput($sformatf("start%0d idle", i), {oBusy, oErr}, 0);
      checkOutput($sformatf("start%0d no writes", i), wrAddrQ.size(), 0);
    end

    $display("[TB] basic 2x2 on slot 1");
    pixList[0] = 24'h0A141E;
    pixList[1] = 24'hFFFFFF;
    pixList[2] = 24'h000000;
    pixList[3] = 24'h010203;
    runJob("t1", 2'd1, 10'd2, 10'd2, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i < wrAddrQ.size())
        checkOutput($sformatf("t1 word%0d", i), {wrAddrQ[i], wrDataQ[i]}, {t1Tab[i].addr, t1Tab[i].data});
    end

    $display("[TB] backpressure 4x3 on slot 0");
    runJob("t2", 2'd0, 10'd4, 10'd3, 1'b1, 1'b0);

    $display("[TB] streaming 3x1");
    runJob("t5", 2'd0, 10'd3, 10'd1, 1'b0, 1'b0);
    checkOutput("t5 back-to-back", lastWrCyc - firstWrCyc, 5);

    $display("[TB] abort during pixel 5");
    for (int i = 0; i < 9; i++) pixList[i] = 24'($urandom);
    pulseClear();
    applyStimulus(2'd0, 10'd3, 10'd3);
    streamPixels("t4", 9, 1'b0, 4);
    @(negedge clk);
    checkOutput("t4 we_n after abort", weN, 1);
    checkOutput("t4 busy after abort", oBusy, 0);
    checkOutput("t4 dq released", sramDq === 16'hzzzz, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t4 words before abort", wrAddrQ.size(), 9);
    checkOutput("t4 no done", doneCnt, 0);
    runJob("t4 restart", 2'd0, 10'd2, 10'd1, 1'b0, 1'b0);

    $display("[TB] start while busy");
    for (int i = 0; i < 4; i++) pixList[i] = 24'($urandom);
    pulseClear();
    applyStimulus(2'd2, 10'd2, 10'd2);
    iStart = 1'b1;
    iSlot = 2'd0;
    iCols = 10'd1;
    iRows = 10'd1;
    @(posedge clk);
    #1 iStart = 1'b0;
    streamPixels("t6", 4, 1'b1, -1);
    waitDone("t6", 40);
    compareWrites("t6", 16, 4);
    checkOutput("t6 no err", errCnt, 0);
    checkOutput("t6 done count", doneCnt, 1);

    $display("[TB] random jobs");
    for (int j = 0; j < 3; j++) begin
      runJob($sformatf("rand%0d", j), 2'($urandom_range(0, 2)), 10'($urandom_range(1, 5)),
             10'($urandom_range(1, 4)), 1'b1, 1'b0);
    end

    $display("[TB] reset during low-word write");
    pixList[0] = 24'h123456;
    pulseClear();
    applyStimulus(2'd1, 10'd1, 10'd2);
    pixRgb = pixList[0];
    pixValid = 1'b1;
    @(posedge clk);
    #1 pixValid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t6 low write active", {weN, sramAddr}, {1'b0, 20'd5});
    rst_n = 1'b0;
    #1;
    checkOutput("t6 async reset ctrl", {weN, oeN, ceN, lbN, ubN, oPixReady, oBusy, oDone, oErr}, 9'b110000000);
    checkOutput("t6 async reset addr", sramAddr, 0);
    checkOutput("t6 async reset dq z", sramDq === 16'hzzzz, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t6 idle after reset", {weN, oBusy, oPixReady}, 3'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
